// File: rtl/hamming_decoder.sv
// SECDED Hamming(16,11) block decoder: reads codewords from memory,
// corrects single errors, flags double errors, writes results back.
module hamming_decoder #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  output logic [3:0] err1_cnt,
  output logic [3:0] err2_cnt
);

  localparam logic [7:0] SRC8 = 8'(SRC_BASE);
  localparam logic [7:0] DST8 = 8'(DST_BASE);
  localparam logic [6:0] LAST = 7'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE
  } state_t;

  state_t      state_q;
  logic [6:0]  idx_q;
  logic [7:0]  lo_q;
  logic [15:0] cw_q;
  logic [7:0]  hi_q;
  logic        done_q;
  logic        busy_q;
  logic [7:0]  addr_q;
  logic        rd_q;
  logic        wr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  e1_q;
  logic [3:0]  e2_q;

  logic [6:0]  idx_nx;
  logic [7:0]  src_a;
  logic [7:0]  dst_a;
  logic [7:0]  src_nx;

  assign idx_nx = idx_q + 7'd1;
  assign src_a  = SRC8 + {idx_q, 1'b0};
  assign dst_a  = DST8 + {idx_q, 1'b0};
  assign src_nx = SRC8 + {idx_nx, 1'b0};

  // Hamming position of data bit j (d[j+1])
  function automatic logic [3:0] dpos(input int j);
    if (j == 0)     return 4'd3;
    else if (j < 4) return 4'(j + 4);
    else            return 4'(j + 5);
  endfunction

  logic [3:0]  syn;
  logic        par;
  logic [1:0]  flags_d;
  logic [10:0] data_d;

  always_comb begin
    syn     = '0;
    par     = ^cw_q;
    flags_d = 2'b00;
    data_d  = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw_q[k]) syn = syn ^ 4'(k);
    end
    if (par)              flags_d = 2'b01;
    else if (syn != 4'd0) flags_d = 2'b10;
    for (int j = 0; j < 11; j++) begin
      data_d[j] = cw_q[dpos(j)] ^ (par && (syn == dpos(j)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      cw_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RD_LO;
            idx_q   <= '0;
            e1_q    <= '0;
            e2_q    <= '0;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= SRC8;
          end
        end
        RD_LO: begin
          state_q <= RD_HI;
          addr_q  <= src_a + 8'd1;
        end
        RD_HI: begin
          state_q <= CAP;
          lo_q    <= mem_rdata;
          rd_q    <= 1'b0;
        end
        CAP: begin
          state_q <= DEC;
          cw_q    <= {mem_rdata, lo_q};
        end
        DEC: begin
          state_q <= WR_LO;
          hi_q    <= {flags_d, 3'b000, data_d[10:8]};
          if (flags_d == 2'b01 && e1_q != 4'hF) e1_q <= e1_q + 4'd1;
          if (flags_d == 2'b10 && e2_q != 4'hF) e2_q <= e2_q + 4'd1;
          wr_q    <= 1'b1;
          addr_q  <= dst_a;
          wdata_q <= data_d[7:0];
        end
        WR_LO: begin
          state_q <= WR_HI;
          addr_q  <= dst_a + 8'd1;
          wdata_q <= hi_q;
        end
        WR_HI: begin
          wr_q <= 1'b0;
          if (idx_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD_LO;
            idx_q   <= idx_nx;
            rd_q    <= 1'b1;
            addr_q  <= src_nx;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;
  assign mem_wdata = wdata_q;
  assign err1_cnt  = e1_q;
  assign err2_cnt  = e2_q;

endmodule

// File: doc/hamming_decoder.md
HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter NUM_WORDS, default 15: number of codewords processed per start.
REQ-002 Parameter SRC_BASE, default 30: byte address of codeword 0 low byte.
REQ-003 Parameter DST_BASE, default 0: byte address of result 0 low byte.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a decode run.
REQ-007 done  output  1  one-cycle pulse: run complete.
REQ-008 busy  output  1  high from the cycle after start is accepted until the done cycle inclusive.
REQ-009 mem_addr  output  8  byte address to data memory.
REQ-010 mem_rd_en  output  1  read strobe; mem_rdata valid the cycle after.
REQ-011 mem_rdata  input  8  read data, one-cycle synchronous latency.
REQ-012 mem_wr_en  output  1  write strobe; memory writes mem_wdata at mem_addr on that edge.
REQ-013 mem_wdata  output  8  write data.
REQ-014 err1_cnt  output  4  count of single-error (corrected) words in the current/last run.
REQ-015 err2_cnt  output  4  count of double-error (uncorrectable) words in the current/last run.

Function
REQ-016 Codeword i SHALL be {mem[SRC_BASE+2i+1], mem[SRC_BASE+2i]}, i = 0..NUM_WORDS-1; bit k = Hamming position k, bit 0 = overall parity p0.
REQ-017 Syndrome s[3:0] SHALL be the XOR of indices k (1..15) of all set codeword bits; P SHALL be the XOR of all 16 bits.
REQ-018 Classification: s=0,P=0 -> flags 00, no change; P=1 -> flags 01, flip bit s (s=0 means p0 flipped, data unchanged); s!=0,P=0 -> flags 10, data passed uncorrected.
REQ-019 Data extraction from (corrected) word cw: d[11:5]=cw[15:9], d[4:2]=cw[7:5], d[1]=cw[3].
REQ-020 Result i SHALL be written: mem[DST_BASE+2i] = d[8:1]; mem[DST_BASE+2i+1] = {flags[1:0], 3'b000, d[11:9]}.
REQ-021 FSM states: IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE.
REQ-022 IDLE: start=1 -> RD_LO, word index i=0, err1_cnt/err2_cnt cleared; otherwise stay.
REQ-023 RD_LO: mem_rd_en=1, addr SRC_BASE+2i -> RD_HI.
REQ-024 RD_HI: mem_rd_en=1, addr SRC_BASE+2i+1, capture low byte from mem_rdata -> CAP.
REQ-025 CAP: capture high byte -> DEC.
REQ-026 DEC: register corrected data and flags; increment err1_cnt or err2_cnt (saturating at 15) -> WR_LO.
REQ-027 WR_LO: mem_wr_en=1, addr DST_BASE+2i, low result byte -> WR_HI.
REQ-028 WR_HI: mem_wr_en=1, addr DST_BASE+2i+1, high result byte; i=NUM_WORDS-1 -> DONE, else i+1 -> RD_LO.
REQ-029 DONE: done=1 for exactly one cycle -> IDLE; counters hold until next accepted start.
REQ-030 Latency: 6 cycles per word; done asserted 6*NUM_WORDS+1 cycles after the start edge (91 for default).
REQ-031 start while busy SHALL be ignored; start coincident with DONE SHALL be ignored.
REQ-032 mem_rd_en and mem_wr_en SHALL never be high in the same cycle; both low in IDLE and DONE.
REQ-033 Address arithmetic SHALL be 8-bit modulo 256.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, i=0, done=0, busy=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, err1_cnt=0, err2_cnt=0.
REQ-035 Reset mid-run SHALL abort immediately with no further memory writes; partial results remain in memory; a new start after reset release begins again at word 0.

Verification
REQ-036 Codeword 0xFFFF (data 0x7FF, no error) -> mem[DST+2i]=0xFF, mem[DST+2i+1]=0x07, counters unchanged.
REQ-037 Codeword 0x0020 (bit 5 flipped from 0x0000) -> low=0x00, high=0x40, err1_cnt +1.
REQ-038 Codeword 0x0001 (p0 only flipped) -> low=0x00, high=0x40.
REQ-039 Codeword 0x0006 (bits 1,2 flipped) -> s=3, P=0 -> low=0x00, high=0x80, err2_cnt +1.
REQ-040 15 random words, 75% single / 25% double flips, start pulsed -> done exactly 91 cycles later; all 30 result bytes and counters match reference model; start pulses during busy have no effect.
REQ-041 rst_n asserted during word 7 WR_LO -> all outputs zero same cycle, words 7..14 unwritten; restart completes full correct run.
